// File: rtl/arb_pkg.sv
// arb_pkg: shared state enum, rotate-left and one-hot helpers for the round-robin scheduler
package arb_pkg;
  localparam int MAXW = 32;
  typedef enum logic {IDLE, LOCK} arb_state_e;
  function automatic logic [MAXW-1:0] rotl(input logic [MAXW-1:0] x, input int w);
    logic [MAXW-1:0] m;
    m = {MAXW{1'b1}} >> (MAXW - w);
    return ((x << 1) | (x >> (w - 1))) & m;
  endfunction
  function automatic logic onehot(input logic [MAXW-1:0] x);
    return (x != '0) && ((x & (x - MAXW'(1))) == '0);
  endfunction
endpackage

// File: rtl/arb_rr_sched.sv
// arb_rr_sched: round-robin priority driver for arb_fp; ARB_RR_SCHED_LOCK_EN adds multi-beat locking with timeout
module arb_rr_sched
  import arb_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LOCK_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] v_vld,
  input  logic [WIDTH-1:0] v_grant,
  input  logic [WIDTH-1:0] v_last,
  output logic [WIDTH-1:0] v_priority,
  output logic [WIDTH-1:0] v_owner,
  output logic             lock_vld,
  output logic             timeout_pulse
);
  logic [WIDTH-1:0] g, g_rot, ptr_q;
  assign g = v_grant & v_vld;
  assign g_rot = WIDTH'(rotl(MAXW'(g), WIDTH));
`ifdef ARB_RR_SCHED_LOCK_EN
  localparam int CW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'((LOCK_MAX > 0) ? LOCK_MAX - 1 : 0);
  arb_state_e state_q;
  logic [WIDTH-1:0] owner_q, own_rot;
  logic [CW-1:0] cnt_q;
  logic tp_q, rel, force_rel;
  assign own_rot = WIDTH'(rotl(MAXW'(owner_q), WIDTH));
  assign rel = |(owner_q & v_vld & v_last);
  assign force_rel = (LOCK_MAX != 0) && (cnt_q == CMAX);
  // IDLE/LOCK scheduler: single-beat grants rotate ptr, multi-beat grants lock the owner until last or timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= WIDTH'(1);
      owner_q <= '0;
      cnt_q <= '0;
      tp_q <= 1'b0;
    end else begin
      tp_q <= 1'b0;
      if (state_q == IDLE) begin
        if (|g) begin
          if (|(g & v_last)) ptr_q <= g_rot;
          else begin
            owner_q <= g;
            cnt_q <= '0;
            state_q <= LOCK;
          end
        end
      end else if (rel || force_rel) begin
        ptr_q <= own_rot;
        owner_q <= '0;
        state_q <= IDLE;
        tp_q <= !rel;
      end else cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CW'(1);
    end
  assign v_priority = (state_q == LOCK) ? owner_q : ptr_q;
  assign v_owner = owner_q;
  assign lock_vld = (state_q == LOCK);
  assign timeout_pulse = tp_q;
`else
  localparam int unused_lock_max = LOCK_MAX;
  logic unused_last;
  assign unused_last = ^v_last;
  // every effective grant moves priority to the requester just above the winner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= WIDTH'(1);
    else if (|g) ptr_q <= g_rot;
  assign v_priority = ptr_q;
  assign v_owner = '0;
  assign lock_vld = 1'b0;
  assign timeout_pulse = 1'b0;
`endif
  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) (g == '0) || onehot(MAXW'(g)));
endmodule

// File: tb/tb_arb_rr_sched.sv
// tb_arb_rr_sched: directed literal checks plus randomized run against a behavioural scheduler model
module tb_arb_rr_sched;
  localparam int W = 4;
  localparam int LM = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] v_vld = '0, v_grant = '0, v_last = '0;
  logic [W-1:0] v_priority, v_owner;
  logic lock_vld, timeout_pulse;
  int total = 0, bad = 0;
  int ptr = 0, owner = 0, lc = 0;
  bit locked = 0, tp = 0;

  always #5 clk = ~clk;

  arb_rr_sched #(.WIDTH(W), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n), .v_vld(v_vld), .v_grant(v_grant), .v_last(v_last),
    .v_priority(v_priority), .v_owner(v_owner), .lock_vld(lock_vld), .timeout_pulse(timeout_pulse)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mreset();
    ptr = 0; owner = 0; lc = 0; locked = 0; tp = 0;
  endtask

  task automatic mstep();
    int gi = -1;
    for (int i = 0; i < W; i++) if (v_grant[i] && v_vld[i]) gi = i;
    tp = 0;
`ifdef ARB_RR_SCHED_LOCK_EN
    if (locked) begin
      if (v_vld[owner] && v_last[owner]) begin locked = 0; ptr = (owner + 1) % W; end
      else if (lc == LM) begin locked = 0; ptr = (owner + 1) % W; tp = 1; end
      else lc++;
    end else if (gi >= 0) begin
      if (v_last[gi]) ptr = (gi + 1) % W;
      else begin locked = 1; owner = gi; lc = 1; end
    end
`else
    if (gi >= 0) ptr = (gi + 1) % W;
`endif
  endtask

  always @(negedge rst_n) mreset();

  always @(posedge clk) begin
    if (!rst_n) mreset(); else mstep();
    #1;
    chk("prio", 32'(v_priority), 32'd1 << (locked ? owner : ptr));
    chk("owner", 32'(v_owner), locked ? (32'd1 << owner) : 32'd0);
    chk("lock_vld", 32'(lock_vld), 32'(locked));
    chk("timeout", 32'(timeout_pulse), 32'(tp));
  end

  task automatic step(input logic [W-1:0] vv, input logic [W-1:0] gg, input logic [W-1:0] ll);
    @(negedge clk);
    v_vld = vv; v_grant = gg; v_last = ll;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [W-1:0] vv, gg, ll;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_prio", 32'(v_priority), 32'h1);
    chk("rst_owner", 32'(v_owner), 32'h0);
    chk("rst_lock", 32'(lock_vld), 32'h0);
    chk("rst_tp", 32'(timeout_pulse), 32'h0);
    @(negedge clk) rst_n = 1'b1;
`ifdef ARB_RR_SCHED_LOCK_EN
    step(4'b1111, 4'b0001, 4'b0001);
    chk("single_prio", 32'(v_priority), 32'h2);
    chk("single_lock", 32'(lock_vld), 32'h0);
    step(4'b1111, 4'b0100, 4'b0000);
    chk("lock_vld", 32'(lock_vld), 32'h1);
    chk("lock_owner", 32'(v_owner), 32'h4);
    chk("lock_prio", 32'(v_priority), 32'h4);
    step(4'b1111, 4'b0100, 4'b0100);
    chk("rel_lock", 32'(lock_vld), 32'h0);
    chk("rel_prio", 32'(v_priority), 32'h8);
    step(4'b1111, 4'b0010, 4'b0000);
    chk("to_lock", 32'(v_owner), 32'h2);
    repeat (3) step(4'b1111, 4'b0000, 4'b0000);
    chk("to_still_lock", 32'(lock_vld), 32'h1);
    chk("to_no_pulse", 32'(timeout_pulse), 32'h0);
    step(4'b1111, 4'b0000, 4'b0000);
    chk("to_idle", 32'(lock_vld), 32'h0);
    chk("to_pulse", 32'(timeout_pulse), 32'h1);
    chk("to_prio", 32'(v_priority), 32'h4);
    step(4'b0000, 4'b0000, 4'b0000);
    chk("to_pulse_end", 32'(timeout_pulse), 32'h0);
    step(4'b1111, 4'b1000, 4'b0000);
    chk("mid_lock", 32'(v_owner), 32'h8);
    #1 rst_n = 1'b0;
    #1;
    chk("async_owner", 32'(v_owner), 32'h0);
    chk("async_lock", 32'(lock_vld), 32'h0);
    chk("async_prio", 32'(v_priority), 32'h1);
    @(negedge clk) rst_n = 1'b1;
`else
    step(4'b1111, 4'b0100, 4'b0000);
    chk("nl_prio", 32'(v_priority), 32'h8);
    chk("nl_lock", 32'(lock_vld), 32'h0);
    step(4'b1111, 4'b1000, 4'b1111);
    chk("nl_wrap", 32'(v_priority), 32'h1);
    chk("nl_lock2", 32'(lock_vld), 32'h0);
    chk("nl_owner", 32'(v_owner), 32'h0);
`endif
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
      vv = 4'($urandom) | 4'($urandom);
      gg = ($urandom_range(4) == 0) ? 4'b0000 : (4'b0001 << $urandom_range(3));
      ll = 4'($urandom) & 4'($urandom);
      step(vv, gg, ll);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
